// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial packed-BCD adder/subtractor.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } bcd_seq_state_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Digit-wise nines complement; adding it plus an initial carry of 1 subtracts.
    function automatic bcd_digit_t bcd_nines(input bcd_digit_t d);
        return BCD_MAX - d;
    endfunction

    function automatic logic bcd_bad(input bcd_digit_t d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit add/subtract step: a + (sub ? 9-b : b) + cin with decimal correction.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    input  logic       sub,
    output bcd_digit_t sum,
    output logic       cout
);

    bcd_digit_t bx;
    logic [4:0] s;
    logic [4:0] s_adj;

    always_comb begin
        bx    = sub ? bcd_nines(b) : b;
        s     = {1'b0, a} + {1'b0, bx} + {4'd0, cin};
        s_adj = s + 5'd6;
        if (s > 5'd9) begin
            sum  = s_adj[3:0];
            cout = 1'b1;
        end else begin
            sum  = s[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Multi-digit packed-BCD adder/subtractor processing one digit per clock, LSD first,
// with valid/ready handshakes on both sides and input-digit validation.
module bcd_addsub_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sub,
    input  logic [4*DIGITS-1:0]   in_a,
    input  logic [4*DIGITS-1:0]   in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_sum,
    output logic                  out_carry,
    output logic                  out_err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    bcd_seq_state_t state, state_nx;

    logic [DIGITS-1:0][3:0] a_q, b_q, sum_q;
    logic                   sub_q, carry_q, err_q;
    logic [IW-1:0]          idx;
    logic                   accept, last, in_err;
    bcd_digit_t             dsum;
    logic                   dcout;

    assign accept = in_valid && (state == IDLE);
    assign last   = (idx == IW'(DIGITS - 1));

    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_bad(in_a[4*i +: 4]) || bcd_bad(in_b[4*i +: 4]))
                in_err = 1'b1;
        end
    end

    // Single digit slice, fed from the captured operands at the current index.
    bcd_digit_add u_digit (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (carry_q),
        .sub  (sub_q),
        .sum  (dsum),
        .cout (dcout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)    state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_q     <= in_a;
                    b_q     <= in_b;
                    sub_q   <= in_sub;
                    carry_q <= in_sub;  // +1 turns nines complement into tens complement
                    err_q   <= in_err;
                    sum_q   <= '0;
                    idx     <= '0;
                end
                RUN: begin
                    sum_q[idx] <= dsum;
                    carry_q    <= dcout;
                    if (!last) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // An invalid operand still runs the full latency but reports a zeroed result.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_sum   = err_q ? '0 : sum_q;
    assign out_carry = carry_q & ~err_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Directed, table-driven bench for bcd_addsub_seq (DIGITS=4) plus backpressure and reset corners.
module tb_bcd_addsub_seq;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_sub;
    logic [W-1:0] in_a, in_b;
    logic         out_valid, out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry, out_err;

    int checks = 0;
    int fails  = 0;

    bcd_addsub_seq #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sub    (in_sub),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         carry;
        logic         err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one operand, wait for the accept edge, then count edges until out_valid.
    // Inputs are scrambled while busy to show they are not resampled.
    task automatic run_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
        in_valid = 1'b1;
        in_sub   = sub;
        in_a     = a;
        in_b     = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_a   = W'($urandom);
            in_b   = W'($urandom);
            in_sub = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " out_valid after retire"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready after retire"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        int lat;

        vecs[0] = '{1'b0, 16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'h4567, 16'h5433, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 16'h0500, 16'h0123, 16'h0377, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 16'h0123, 16'h0500, 16'h9623, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 16'h0A00, 16'h0001, 16'h0000, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 16'h0000, 16'h0001, 16'h9999, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready",  32'(in_ready),  32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_sum",   32'(out_sum),   32'd0);
        chk("reset out_carry", 32'(out_carry), 32'd0);
        chk("reset out_err",   32'(out_err),   32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Accept at edge k, DONE visible after edge k+DIGITS (cycle k+DIGITS+1).
        foreach (vecs[i]) begin
            chk($sformatf("v%0d in_ready idle", i), 32'(in_ready), 32'd1);
            run_op(vecs[i].sub, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d latency", i),   32'(lat),       32'(DIGITS));
            chk($sformatf("v%0d out_sum", i),   32'(out_sum),   32'(vecs[i].sum));
            chk($sformatf("v%0d out_carry", i), 32'(out_carry), 32'(vecs[i].carry));
            chk($sformatf("v%0d out_err", i),   32'(out_err),   32'(vecs[i].err));
            chk($sformatf("v%0d in_ready busy", i), 32'(in_ready), 32'd0);
            retire($sformatf("v%0d", i));
        end

        // Backpressure: hold DONE with a competing operand offered.
        run_op(1'b0, 16'h1234, 16'h4321, lat);
        chk("bp latency", 32'(lat), 32'(DIGITS));
        in_valid = 1'b1; in_sub = 1'b0; in_a = 16'h0002; in_b = 16'h0003;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp hold%0d out_sum", c),   32'(out_sum),   32'h5555);
            chk($sformatf("bp hold%0d in_ready", c),  32'(in_ready),  32'd0);
        end
        // Retire with in_valid still high: new op only accepted on the following edge.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp retire out_valid", 32'(out_valid), 32'd0);
        chk("bp retire in_ready",  32'(in_ready),  32'd1);
        run_op(1'b0, 16'h0002, 16'h0003, lat);
        chk("bp next latency", 32'(lat),     32'(DIGITS));
        chk("bp next out_sum", 32'(out_sum), 32'h0005);
        retire("bp next");

        // Reset while digit 2 is being processed.
        in_valid = 1'b1; in_sub = 1'b0; in_a = 16'h5555; in_b = 16'h1111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort in_ready",  32'(in_ready),  32'd1);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort out_sum",   32'(out_sum),   32'd0);
        run_op(1'b0, 16'h0001, 16'h0001, lat);
        chk("post-abort latency", 32'(lat),       32'(DIGITS));
        chk("post-abort out_sum", 32'(out_sum),   32'h0002);
        chk("post-abort carry",   32'(out_carry), 32'd0);
        retire("post-abort");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
